// File: rtl/iir_voice_bank_if.sv
// Sweep control, sample/DEL fetch and filtered output bus for the IIR voice bank.
// No flow control: fetches are answered combinationally and outputs are strobes with no ready.
interface iir_voice_bank_if #(
    parameter int VOICES = 8,
    parameter int DW     = 18
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic                   start;
    logic                   mode_hp;
    logic                   in_rd;
    logic [VW-1:0]          in_voice;
    logic signed [DW-1:0]   in_data;
    logic signed [2*DW-1:0] del_in;
    logic                   out_valid;
    logic [VW-1:0]          out_voice;
    logic signed [DW-1:0]   out_data;
    logic                   busy;
    logic                   done;

    modport slave (
        input  start, mode_hp, in_data, del_in,
        output in_rd, in_voice, out_valid, out_voice, out_data, busy, done
    );

    modport master (
        output start, mode_hp, in_data, del_in,
        input  in_rd, in_voice, out_valid, out_voice, out_data, busy, done
    );
endinterface

// File: rtl/iir_voice_bank.sv
// Time-multiplexed bank of cascaded one-pole IIR LP/HP sections; 3 cycles per (voice, stage).
// Sweep takes 3*VOICES*STAGES cycles; no backpressure, starts while busy are dropped.
module iir_voice_bank #(
    parameter int VOICES = 8,
    parameter int STAGES = 2,
    parameter int DW     = 18
) (
    input  logic           clk,
    input  logic           reset,
    iir_voice_bank_if.slave bus
);
    localparam int VS = VOICES * STAGES;
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int AW = (VS > 1) ? $clog2(VS) : 1;
    localparam logic [2*DW-1:0] MAXDEL = {1'b0, {(2*DW-1){1'b1}}};
    localparam logic [VW-1:0] V_LAST = VW'(VOICES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STAGES - 1);
    localparam logic [AW-1:0] A_LAST = AW'(VS - 1);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_FETCH, S_MUL, S_WRB} state_t;

    state_t                 state, state_nx;
    logic [AW-1:0]          clr_cnt;
    logic [VW-1:0]          voice;
    logic [SW-1:0]          stage;
    logic                   mode_r;
    logic [2*DW-1:0]        del_r;
    logic signed [DW-1:0]   x_r, y_rd, res_r;
    logic signed [2*DW-1:0] prod_a, prod_b;
    logic signed [DW-1:0]   ram [VS];

    logic                   last_stage, last_voice;
    logic [AW-1:0]          addr;
    logic signed [DW-1:0]   b1, a0, lp_sat, hp_sat;
    logic signed [DW:0]     lp_wide, hp_wide;
    logic                   ram_we;
    logic [AW-1:0]          ram_wa;
    logic signed [DW-1:0]   ram_wd;

    function automatic logic signed [DW-1:0] sat1(input logic signed [DW:0] v);
        if (v[DW] != v[DW-1])
            sat1 = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat1 = v[DW-1:0];
    endfunction

    always_comb begin
        last_stage = (stage == S_LAST);
        last_voice = (voice == V_LAST);
        addr       = AW'(voice) * AW'(STAGES) + AW'(stage);
        b1         = del_r[2*DW-1:DW];
        a0         = DW'((MAXDEL - del_r) >> DW);
        // (pA+pB)<<1 at 2*DW+1 bits, then >>>DW: the kept bits are sum[2*DW-1:DW-1]
        lp_wide    = (DW+1)'(({prod_a[2*DW-1], prod_a} + {prod_b[2*DW-1], prod_b}) >> (DW-1));
        lp_sat     = sat1(lp_wide);
        hp_wide    = {x_r[DW-1], x_r} - {lp_sat[DW-1], lp_sat};
        hp_sat     = sat1(hp_wide);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_CLEAR;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.in_rd    = 1'b0;
        bus.in_voice = '0;
        case (state)
            S_CLEAR: if (clr_cnt == A_LAST) state_nx = S_IDLE;
            // a start landing in the done cycle is dropped
            S_IDLE:  if (bus.start && !bus.done) state_nx = S_FETCH;
            S_FETCH: begin
                state_nx = S_MUL;
                if (stage == '0) begin
                    bus.in_rd    = 1'b1;
                    bus.in_voice = voice;
                end
            end
            S_MUL:   state_nx = S_WRB;
            S_WRB:   state_nx = (last_stage && last_voice) ? S_IDLE : S_FETCH;
            default: state_nx = S_CLEAR;
        endcase
    end

    assign bus.busy = (state != S_IDLE) || bus.done;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt       <= '0;
            voice         <= '0;
            stage         <= '0;
            mode_r        <= 1'b0;
            del_r         <= '0;
            x_r           <= '0;
            res_r         <= '0;
            prod_a        <= '0;
            prod_b        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_voice <= '0;
            bus.out_data  <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                S_CLEAR: clr_cnt <= clr_cnt + AW'(1);
                S_IDLE: if (state_nx == S_FETCH) begin
                    voice  <= '0;
                    stage  <= '0;
                    mode_r <= bus.mode_hp;
                end
                S_FETCH: begin
                    if (stage == '0) begin
                        x_r   <= bus.in_data;
                        del_r <= bus.del_in;
                    end else begin
                        x_r <= res_r;
                    end
                end
                S_MUL: begin
                    prod_a <= $signed({{DW{x_r[DW-1]}}, x_r}) * $signed({{DW{a0[DW-1]}}, a0});
                    prod_b <= $signed({{DW{y_rd[DW-1]}}, y_rd}) * $signed({{DW{b1[DW-1]}}, b1});
                end
                S_WRB: begin
                    res_r <= lp_sat;
                    if (last_stage) begin
                        bus.out_valid <= 1'b1;
                        bus.out_voice <= voice;
                        bus.out_data  <= mode_r ? hp_sat : lp_sat;
                        stage         <= '0;
                        if (last_voice)
                            bus.done <= 1'b1;
                        else
                            voice <= voice + VW'(1);
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State RAM always holds the lowpass value, even in HP mode.
    always_comb begin
        ram_we = (state == S_CLEAR) || (state == S_WRB && !reset);
        ram_wa = (state == S_CLEAR) ? clr_cnt : addr;
        ram_wd = (state == S_CLEAR) ? '0 : lp_sat;
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_wa] <= ram_wd;
        y_rd <= ram[addr];
    end
endmodule

// File: tb/tb_iir_voice_bank.sv
// Drives two banks (STAGES=1 and STAGES=2) with identical stimulus and checks every cycle
// against an arithmetic model of the filter recursion and sweep timing.
module tb_iir_voice_bank;
    localparam int V  = 8;
    localparam int DW = 18;
    localparam longint MAXDEL = (longint'(1) << 35) - 1;
    localparam longint DEL_HALF = longint'(1) << 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_s = 1'b1;
    logic start_s = 1'b0;
    logic mode_s  = 1'b0;
    logic signed [17:0] dat_tab [V];
    logic signed [35:0] del_tab [V];

    iir_voice_bank_if #(.VOICES(V), .DW(DW)) bus1 ();
    iir_voice_bank_if #(.VOICES(V), .DW(DW)) bus2 ();

    assign bus1.start   = start_s;
    assign bus1.mode_hp = mode_s;
    assign bus1.in_data = dat_tab[bus1.in_voice];
    assign bus1.del_in  = del_tab[bus1.in_voice];
    assign bus2.start   = start_s;
    assign bus2.mode_hp = mode_s;
    assign bus2.in_data = dat_tab[bus2.in_voice];
    assign bus2.del_in  = del_tab[bus2.in_voice];

    iir_voice_bank #(.VOICES(V), .STAGES(1), .DW(DW)) dut1 (.clk(clk), .reset(reset_s), .bus(bus1));
    iir_voice_bank #(.VOICES(V), .STAGES(2), .DW(DW)) dut2 (.clk(clk), .reset(reset_s), .bus(bus2));

    int total = 0;
    int bad   = 0;
    int t     = 0;
    bit chk_en = 1'b0;

    // model state: index 0 = STAGES=1 bank, index 1 = STAGES=2 bank
    longint st [2][V][2];
    int     rd_t [2][V];
    int     out_t [2][V];
    longint out_d [2][V];
    int     done_t [2];
    int     busy_last [2];
    int     nvalid [2];
    int     ndone [2];
    longint cap [2][V];

    function automatic int nst(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic longint sat(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    task automatic model_start(input int d, input int e, input bit hp);
        int s_n = nst(d);
        for (int v = 0; v < V; v++) begin
            longint x  = longint'(dat_tab[v]);
            longint dl = longint'(del_tab[v]);
            longint b1 = dl >>> 18;
            longint a0 = (MAXDEL - dl) >>> 18;
            longint o  = 0;
            for (int s = 0; s < s_n; s++) begin
                longint yn = sat(((x * a0 + st[d][v][s] * b1) * 2) >>> 18);
                st[d][v][s] = yn;
                o = (s == s_n - 1 && hp) ? sat(x - yn) : yn;
                x = yn;
            end
            rd_t[d][v]  = e + 3 * s_n * v;
            out_t[d][v] = e + 3 * s_n * (v + 1);
            out_d[d][v] = o;
        end
        done_t[d]    = e + 3 * s_n * V;
        busy_last[d] = done_t[d];
    endtask

    always @(posedge clk) begin
        t = t + 1;
        for (int d = 0; d < 2; d++) begin
            if (reset_s) begin
                chk_en       = 1'b1;
                done_t[d]    = -1;
                busy_last[d] = t + V * nst(d) - 1;
                for (int v = 0; v < V; v++) begin
                    rd_t[d][v]  = -1;
                    out_t[d][v] = -1;
                    st[d][v][0] = 0;
                    st[d][v][1] = 0;
                end
            end else if (start_s && (t - 1 > busy_last[d])) begin
                model_start(d, t, mode_s);
            end
        end
    end

    task automatic check_dut(input int d, input logic rd, input logic [2:0] rv, input logic ov,
                             input logic [2:0] ovo, input logic signed [17:0] od,
                             input logic bz, input logic dn);
        bit     erd  = 1'b0;
        bit     eov  = 1'b0;
        int     erv  = 0;
        int     eovo = 0;
        longint eod  = 0;
        for (int v = 0; v < V; v++) begin
            if (rd_t[d][v] == t) begin erd = 1'b1; erv = v; end
            if (out_t[d][v] == t) begin eov = 1'b1; eovo = v; eod = out_d[d][v]; end
        end
        chk($sformatf("busy[%0d]", d), longint'(bz), longint'(t <= busy_last[d]));
        chk($sformatf("in_rd[%0d]", d), longint'(rd), longint'(erd));
        chk($sformatf("out_valid[%0d]", d), longint'(ov), longint'(eov));
        chk($sformatf("done[%0d]", d), longint'(dn), longint'(t == done_t[d]));
        if (erd && rd)
            chk($sformatf("in_voice[%0d]", d), longint'(rv), longint'(erv));
        if (eov && ov) begin
            chk($sformatf("out_voice[%0d]", d), longint'(ovo), longint'(eovo));
            chk($sformatf("out_data[%0d]v%0d", d, eovo), longint'(od), eod);
        end
        if (ov) begin
            cap[d][ovo] = longint'(od);
            nvalid[d]++;
        end
        if (dn) ndone[d]++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, bus1.in_rd, bus1.in_voice, bus1.out_valid, bus1.out_voice,
                      bus1.out_data, bus1.busy, bus1.done);
            check_dut(1, bus2.in_rd, bus2.in_voice, bus2.out_valid, bus2.out_voice,
                      bus2.out_data, bus2.busy, bus2.done);
        end
    end

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            nvalid[d] = 0;
            ndone[d]  = 0;
            for (int v = 0; v < V; v++) cap[d][v] = -999999;
        end
    endtask

    task automatic set_tabs(input longint x, input longint dl);
        for (int v = 0; v < V; v++) begin
            dat_tab[v] = 18'(x);
            del_tab[v] = 36'(dl);
        end
    endtask

    task automatic rand_tabs();
        for (int v = 0; v < V; v++) begin
            dat_tab[v] = 18'($urandom_range(0, 262143));
            del_tab[v] = {1'b0, 3'($urandom_range(0, 7)), 32'($urandom)};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_s = 1'b1;
        @(negedge clk);
        reset_s = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus1.busy || bus2.busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", longint'(bus1.busy | bus2.busy), 0);
    endtask

    task automatic sweep(input bit hp);
        mode_s = hp;
        clear_counts();
        pulse_start();
        wait_idle();
    endtask

    initial begin
        int n1, n2, n;
        longint prev;
        set_tabs(0, 0);
        for (int d = 0; d < 2; d++) begin
            busy_last[d] = -100;
            done_t[d]    = -1;
            for (int v = 0; v < V; v++) begin
                rd_t[d][v]  = -1;
                out_t[d][v] = -1;
            end
        end
        clear_counts();
        repeat (2) @(negedge clk);

        // 1: reset -> CLEAR for VOICES*STAGES cycles with quiet outputs
        do_reset();
        n1 = 0;
        n2 = 0;
        chk("rst_out_data", longint'(bus2.out_data), 0);
        chk("rst_out_voice", longint'(bus2.out_voice), 0);
        for (int i = 0; i < 24; i++) begin
            n1 += int'(bus1.busy);
            n2 += int'(bus2.busy);
            @(negedge clk);
        end
        chk("clear_len_s1", n1, 8);
        chk("clear_len_s2", n2, 16);

        // 2: passthrough
        set_tabs('h10000, 0);
        sweep(1'b0);
        for (int v = 0; v < V; v++) chk("t2_out", cap[1][v], 'h0FFFE);
        chk("t2_model_pin", out_d[1][3], 'h0FFFE);
        chk("t2_s1_out", cap[0][5], 'h0FFFF);
        chk("t2_nvalid", nvalid[1], 8);
        chk("t2_ndone", ndone[1], 1);

        // 3: recursion on the STAGES=1 bank
        do_reset();
        wait_idle();
        set_tabs('h10000, DEL_HALF);
        sweep(1'b0);
        for (int v = 0; v < V; v++) chk("t3_first", cap[0][v], 'h07FFF);
        chk("t3_s2_first", cap[1][0], 'h03FFF);
        prev = cap[0][0];
        for (int k = 0; k < 3; k++) begin
            sweep(1'b0);
            chk("t3_rise", longint'(cap[0][0] > prev), 1);
            chk("t3_bound", longint'(cap[0][0] < 'h10000), 1);
            prev = cap[0][0];
        end

        // 4: HP saturation, LP state retained
        do_reset();
        wait_idle();
        set_tabs(-'h20000, 0);
        sweep(1'b0);
        chk("t4_lp_neg", cap[0][0], -'h1FFFF);
        set_tabs('h1FFFF, MAXDEL);
        sweep(1'b1);
        for (int v = 0; v < V; v++) chk("t4_hp_clamp", cap[0][v], 'h1FFFF);
        set_tabs(0, MAXDEL);
        sweep(1'b0);
        chk("t4_state_lp", cap[0][2], -'h1FFFF);

        // 5: starts during a sweep and in the done cycle are dropped
        rand_tabs();
        mode_s = 1'b0;
        clear_counts();
        pulse_start();
        repeat (5) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!bus2.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done_seen", longint'(bus2.done), 1);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_idle();
        chk("t5_ndone", ndone[1], 1);
        chk("t5_nvalid", nvalid[1], 8);

        // 6: reset mid-sweep aborts and zeroes state
        rand_tabs();
        clear_counts();
        pulse_start();
        repeat (9) @(negedge clk);
        do_reset();
        wait_idle();
        chk("t6_no_done", ndone[1], 0);
        set_tabs('h10000, 0);
        sweep(1'b0);
        for (int v = 0; v < V; v++) chk("t6_out", cap[1][v], 'h0FFFE);
        chk("t6_ndone", ndone[1], 1);
        do_reset();
        wait_idle();
        set_tabs('h10000, DEL_HALF);
        sweep(1'b0);
        chk("t6_zeroed_s1", cap[0][4], 'h07FFF);
        chk("t6_zeroed_s2", cap[1][4], 'h03FFF);

        // randomized sweeps with stray starts
        for (int k = 0; k < 8; k++) begin
            rand_tabs();
            mode_s = 1'($urandom_range(0, 1));
            pulse_start();
            repeat ($urandom_range(1, 40)) @(negedge clk);
            start_s = 1'($urandom_range(0, 1));
            @(negedge clk);
            start_s = 1'b0;
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
